// File: rtl/msg_uart_pkg.sv
// msg_uart_pkg: definitions shared by the message unit and the UART
// transmitter. It holds the transmitter state type and encodings, the default
// baud divider, and the ASCII codes the message unit uses to build its text.
package msg_uart_pkg;

    // 50 MHz / 115200 baud, rounded down
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_I     = 8'h49;
    localparam logic [7:0] ASCII_M     = 8'h4D;
    localparam logic [7:0] ASCII_B     = 8'h42;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_U     = 8'h55;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_2     = 8'h32;
    localparam logic [7:0] ASCII_3     = 8'h33;
    localparam logic [7:0] ASCII_4     = 8'h34;

endpackage

// File: rtl/msg_byte_fifo.sv
// msg_byte_fifo: synchronous byte FIFO that buffers message bytes ahead of the
// UART transmitter.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset (empties the FIFO, clears overflow)
//   wr_en    : write strobe; accepted only when not full
//   wr_data  : byte to append
//   rd_en    : pop strobe; honoured only when not empty
//   rd_data  : head byte (valid while not empty)
//   full     : DEPTH bytes held (registered)
//   empty    : no bytes held (registered)
//   level    : byte count (registered)
//   overflow : sticky, set the cycle after a write is dropped while full
// DEPTH must be a power of two (4..64) so the pointers wrap naturally.
module msg_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    import msg_uart_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    always_comb begin
        // Gating on the registered flags keeps a write at full dropped even
        // when the same edge pops.
        push       = wr_en & ~full_q;
        pop        = rd_en & ~empty_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (wr_en & full_q);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/msg_uart_tx.sv
// msg_uart_tx: buffered 8N1 UART transmitter for the message unit.
//   clk_50M  : system clock, rising edge
//   rst_n    : synchronous active-low reset; aborts any frame, empties buffer
//   wr_en    : byte write strobe
//   wr_data  : ASCII byte to send
//   full     : buffer holds FIFO_DEPTH bytes
//   empty    : buffer holds no bytes
//   level    : buffered byte count
//   overflow : sticky, a write was dropped because the buffer was full
//   busy     : a frame is in progress
//   tx       : serial line, idle high, LSB first
module msg_uart_tx
    import msg_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk_50M,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             pop;
    logic             bit_done;
    logic [7:0]       fifo_rd_data;

    msg_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_50M),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // tx_d always carries the level of the bit period being entered, so the
    // registered line changes exactly on bit-period boundaries.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        bit_done  = (bit_cnt_q == BIT_LAST);
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rd_data;
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                idx_d     = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign tx   = tx_q;

endmodule

// File: tb/tb_msg_uart_tx.sv
// tb_msg_uart_tx: directed bench for msg_uart_tx. One instance runs at the
// production divider (434) for the frame-timing checks, a second runs at a
// divider of 8 so buffer-depth and reset scenarios stay short.
module tb_msg_uart_tx;
    import msg_uart_pkg::*;

    localparam int CPB_S = 434;
    localparam int CPB_F = 8;

    logic       clk = 1'b0;
    logic       rst_n_s, wr_en_s;
    logic [7:0] wr_data_s;
    logic       full_s, empty_s, overflow_s, busy_s, tx_s;
    logic [4:0] level_s;
    logic       rst_n_f, wr_en_f;
    logic [7:0] wr_data_f;
    logic       full_f, empty_f, overflow_f, busy_f, tx_f;
    logic [4:0] level_f;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int max_lvl    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (int'(level_f) > max_lvl) max_lvl <= int'(level_f);

    msg_uart_tx #(.CLKS_PER_BIT(CPB_S), .FIFO_DEPTH(16)) dut_s (
        .clk_50M(clk), .rst_n(rst_n_s), .wr_en(wr_en_s), .wr_data(wr_data_s),
        .full(full_s), .empty(empty_s), .level(level_s), .overflow(overflow_s),
        .busy(busy_s), .tx(tx_s)
    );

    msg_uart_tx #(.CLKS_PER_BIT(CPB_F), .FIFO_DEPTH(16)) dut_f (
        .clk_50M(clk), .rst_n(rst_n_f), .wr_en(wr_en_f), .wr_data(wr_data_f),
        .full(full_f), .empty(empty_f), .level(level_f), .overflow(overflow_f),
        .busy(busy_f), .tx(tx_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txm(input bit s);
        return s ? tx_f : tx_s;
    endfunction

    // Returns at the first negedge where tx is low; t is the cycle stamp.
    task automatic wait_start(input bit s, output int t);
        int n;
        int lim;
        lim = 20 * (s ? CPB_F : CPB_S) + 100;
        n = 0;
        while (txm(s) !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(n >= lim), 0);
        t = cyc;
    endtask

    // Checks every cycle of a full frame against {stop, data, start}.
    task automatic rx_frame(input bit s, input logic [7:0] exp, input string tag,
                            output int t, output logic e);
        int cpb;
        int errs;
        logic [9:0] pat;
        logic [7:0] got;
        cpb = s ? CPB_F : CPB_S;
        pat = {1'b1, exp, 1'b0};
        wait_start(s, t);
        e = s ? empty_f : empty_s;
        errs = 0;
        got = '0;
        for (int k = 0; k < 10 * cpb; k++) begin
            if (k > 0) @(negedge clk);
            if (txm(s) !== pat[k / cpb]) errs++;
            if ((k % cpb) == cpb / 2 && (k / cpb) >= 1 && (k / cpb) <= 8)
                got[(k / cpb) - 1] = txm(s);
        end
        check({tag, "_bits"}, errs, 0);
        check({tag, "_byte"}, {24'h0, got}, {24'h0, exp});
    endtask

    task automatic quiet(input bit s, input int n, input string tag);
        int lows;
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (txm(s) !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fim [4];
        logic [7:0] b7 [7];
        logic [7:0] b4 [4];
        int ts [4];
        logic es [4];
        int t;
        logic e;

        fim = '{ASCII_F, ASCII_I, ASCII_M, ASCII_DASH};
        b7  = '{ASCII_B, ASCII_U, ASCII_S, ASCII_D, ASCII_E, ASCII_C, ASCII_R};
        b4  = '{ASCII_HASH, ASCII_1, ASCII_2, ASCII_3};

        rst_n_s = 1'b0; wr_en_s = 1'b0; wr_data_s = '0;
        rst_n_f = 1'b0; wr_en_f = 1'b0; wr_data_f = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_s", tx_s, 1);        check("rst_busy_s", busy_s, 0);
        check("rst_level_s", level_s, 0);  check("rst_empty_s", empty_s, 1);
        check("rst_full_s", full_s, 0);    check("rst_ovf_s", overflow_s, 0);
        check("rst_tx_f", tx_f, 1);        check("rst_busy_f", busy_f, 0);
        check("rst_level_f", level_f, 0);  check("rst_empty_f", empty_f, 1);
        check("rst_full_f", full_f, 0);    check("rst_ovf_f", overflow_f, 0);
        rst_n_s = 1'b1; rst_n_f = 1'b1;
        @(negedge clk);

        // Single 'F' at 434 clocks per bit
        wr_data_s = ASCII_F; wr_en_s = 1'b1;
        @(negedge clk);
        wr_en_s = 1'b0;
        check("wr1_tx", tx_s, 1);          check("wr1_level", level_s, 1);
        check("wr1_empty", empty_s, 0);    check("wr1_busy", busy_s, 0);
        @(negedge clk);
        check("pop_tx", tx_s, 0);          check("pop_busy", busy_s, 1);
        check("pop_level", level_s, 0);    check("pop_empty", empty_s, 1);
        rx_frame(0, ASCII_F, "f46", t, e);
        @(negedge clk);
        check("f46_busy_after", busy_s, 0);
        check("f46_tx_after", tx_s, 1);

        // "FIM-" on consecutive cycles
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    wr_data_s = fim[i]; wr_en_s = 1'b1;
                    @(negedge clk);
                end
                wr_en_s = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) rx_frame(0, fim[i], "fim", ts[i], es[i]);
            end
        join
        check("fim_gap01", ts[1] - ts[0], 4341);
        check("fim_gap12", ts[2] - ts[1], 4341);
        check("fim_gap23", ts[3] - ts[2], 4341);
        check("fim_empty_at_1st", es[0], 0);
        check("fim_empty_at_4th", es[3], 1);
        check("fim_level_end", level_s, 0);

        // 17 writes while a frame is in flight: the 17th is dropped
        wr_data_f = ASCII_P; wr_en_f = 1'b1;
        @(negedge clk);
        wr_en_f = 1'b0;
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 17; i++) begin
                    wr_data_f = 8'(8'hA0 + i); wr_en_f = 1'b1;
                    @(negedge clk);
                    if (i == 15) begin
                        check("ovf16_level", level_f, 16);
                        check("ovf16_full", full_f, 1);
                        check("ovf16_flag", overflow_f, 0);
                    end
                end
                wr_en_f = 1'b0;
                check("ovf17_flag", overflow_f, 1);
                check("ovf17_level", level_f, 16);
                check("ovf17_full", full_f, 1);
                check("ovf17_empty", empty_f, 0);
            end
            begin
                rx_frame(1, ASCII_P, "primer", t, e);
                for (int i = 0; i < 16; i++) rx_frame(1, 8'(8'hA0 + i), "ovf_data", t, e);
            end
        join
        quiet(1, 200, "ovf_no_17th");
        check("ovf_sticky", overflow_f, 1);
        check("ovf_drained_level", level_f, 0);
        check("ovf_drained_empty", empty_f, 1);
        check("ovf_max_level", max_lvl, 16);

        // Write and pop on the same edge at level 5
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_data_f = b7[i]; wr_en_f = 1'b1;
                    @(negedge clk);
                end
                wr_en_f = 1'b0;
                check("wp_level_before", level_f, 5);
            end
            begin
                rx_frame(1, b7[0], "wp_first", t, e);
                @(negedge clk);
                check("wp_idle_busy", busy_f, 0);
                check("wp_idle_tx", tx_f, 1);
                check("wp_idle_level", level_f, 5);
                wr_data_f = b7[6]; wr_en_f = 1'b1;
                @(negedge clk);
                wr_en_f = 1'b0;
                check("wp_level_after", level_f, 5);
                check("wp_busy_after", busy_f, 1);
                for (int i = 1; i < 7; i++) rx_frame(1, b7[i], "wp_order", t, e);
            end
        join
        check("wp_empty_end", empty_f, 1);

        // Reset during DATA bit 3 of the 2nd byte of a 4-byte burst
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    wr_data_f = b4[i]; wr_en_f = 1'b1;
                    @(negedge clk);
                end
                wr_en_f = 1'b0;
            end
            begin
                rx_frame(1, b4[0], "rb_first", t, e);
                wait_start(1, t);
                repeat (4 * CPB_F + 2) @(negedge clk);
                check("rb_bit3", tx_f, 0);
                check("rb_busy_pre", busy_f, 1);
                check("rb_level_pre", level_f, 2);
                rst_n_f = 1'b0;
                wr_data_f = ASCII_4; wr_en_f = 1'b1;
                @(negedge clk);
                check("rb_tx", tx_f, 1);          check("rb_busy", busy_f, 0);
                check("rb_level", level_f, 0);    check("rb_empty", empty_f, 1);
                check("rb_full", full_f, 0);      check("rb_ovf", overflow_f, 0);
                rst_n_f = 1'b1; wr_en_f = 1'b0;
                quiet(1, 300, "rb_no_frames");
                check("rb_level_end", level_f, 0);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
